// File: rtl/vanilla_scoreboard_tracker_pkg.sv
// Shared definitions for the vanilla core scoreboard latency tracker.
//   sb_class_e : long-latency op classes that a scoreboard entry can hold.
//   sb_*_c     : default parameter values used by the tracker and its users.
package vanilla_scoreboard_tracker_pkg;

  typedef enum logic [2:0] {
    IDIV                 = 3'd0,
    FDIV_FSQRT           = 3'd1,
    REMOTE_DRAM_LOAD     = 3'd2,
    REMOTE_GLOBAL_LOAD   = 3'd3,
    REMOTE_GROUP_LOAD    = 3'd4,
    REMOTE_DRAM_AMO      = 3'd5,
    REMOTE_DRAM_SEQ_LOAD = 3'd6,
    SPARE                = 3'd7
  } sb_class_e;

  localparam int sb_reg_els_c     = 32;
  localparam int sb_num_classes_c = 8;
  localparam int sb_age_width_c   = 16;
  localparam int sb_stat_width_c  = 32;
  localparam bit sb_ignore_reg0_c = 1'b1;

endpackage

// File: rtl/vanilla_sb_class_stats.sv
// Per-class statistics for the scoreboard latency tracker.
// Ports:
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   clear_stats_i    : synchronous clear of every counter (wins over updates)
//   done_v_i         : an entry of this class completes this cycle
//   done_age_i       : latency of the completing entry
//   stall_v_i        : ID stalls this cycle on an entry of this class
//   done_count_o     : completions (saturating)
//   lat_sum_o        : summed latency (saturating, never wraps)
//   lat_max_o        : largest latency seen
//   stall_cycles_o   : stall cycles attributed (saturating)
module vanilla_sb_class_stats #(
  parameter int age_width_p  = 16,
  parameter int stat_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_stats_i,
  input  logic                    done_v_i,
  input  logic [age_width_p-1:0]  done_age_i,
  input  logic                    stall_v_i,
  output logic [stat_width_p-1:0] done_count_o,
  output logic [stat_width_p-1:0] lat_sum_o,
  output logic [age_width_p-1:0]  lat_max_o,
  output logic [stat_width_p-1:0] stall_cycles_o
);

  // One extra bit so the sum can be compared against the counter maximum
  // regardless of which of the two operand widths is larger.
  localparam int sum_w_lp = ((stat_width_p > age_width_p) ? stat_width_p : age_width_p) + 1;
  localparam logic [sum_w_lp-1:0] stat_max_lp = sum_w_lp'({stat_width_p{1'b1}});

  logic [sum_w_lp-1:0] sum_ext;

  assign sum_ext = sum_w_lp'(lat_sum_o) + sum_w_lp'(done_age_i);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the statements appear in.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      done_count_o   <= '0;
      lat_sum_o      <= '0;
      lat_max_o      <= '0;
      stall_cycles_o <= '0;
    end else if (clear_stats_i) begin
      done_count_o   <= '0;
      lat_sum_o      <= '0;
      lat_max_o      <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (done_v_i) begin
        if (done_count_o != '1) done_count_o <= done_count_o + 1'b1;
        lat_sum_o <= (sum_ext > stat_max_lp) ? '1 : lat_sum_o + stat_width_p'(done_age_i);
        if (done_age_i > lat_max_o) lat_max_o <= done_age_i;
      end
      if (stall_v_i && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end

endmodule

// File: rtl/vanilla_scoreboard_latency_tracker.sv
// Scoreboard monitor for one vanilla core register file. Tracks which
// registers wait on a long-latency op, the class of that op and its age, and
// reports per-class completion/latency/stall statistics.
// Ports:
//   clk_i, reset_i            : clock, asynchronous active-high reset
//   set_v_i/set_id_i/set_class_i : op issued that will write set_id_i late
//   clear_v_i/clear_id_i      : writeback clears clear_id_i this cycle
//   stall_v_i/stall_id_i      : ID stalled on the scoreboard for stall_id_i
//   clear_stats_i             : synchronous clear of all statistics
//   pending_o                 : per register, one-hot class of pending op
//   outstanding_o             : pending entries per class
//   done_count_o, lat_sum_o, lat_max_o, stall_cycles_o : per-class stats
//   spurious_clear_o          : clears of non-pending registers
//   overwrite_o               : sets to pending registers with no same-cycle clear
module vanilla_scoreboard_latency_tracker
  import vanilla_scoreboard_tracker_pkg::*;
#(
  parameter int reg_els_p     = sb_reg_els_c,
  parameter int num_classes_p = sb_num_classes_c,
  parameter int age_width_p   = sb_age_width_c,
  parameter int stat_width_p  = sb_stat_width_c,
  parameter bit ignore_reg0_p = sb_ignore_reg0_c,
  localparam int id_w_lp      = $clog2(reg_els_p),
  localparam int cls_w_lp     = (num_classes_p > 1) ? $clog2(num_classes_p) : 1
) (
  input  logic                                            clk_i,
  input  logic                                            reset_i,
  input  logic                                            set_v_i,
  input  logic [id_w_lp-1:0]                              set_id_i,
  input  logic [cls_w_lp-1:0]                             set_class_i,
  input  logic                                            clear_v_i,
  input  logic [id_w_lp-1:0]                              clear_id_i,
  input  logic                                            stall_v_i,
  input  logic [id_w_lp-1:0]                              stall_id_i,
  input  logic                                            clear_stats_i,
  output logic [reg_els_p-1:0][num_classes_p-1:0]         pending_o,
  output logic [num_classes_p-1:0][id_w_lp:0]             outstanding_o,
  output logic [num_classes_p-1:0][stat_width_p-1:0]      done_count_o,
  output logic [num_classes_p-1:0][stat_width_p-1:0]      lat_sum_o,
  output logic [num_classes_p-1:0][age_width_p-1:0]       lat_max_o,
  output logic [num_classes_p-1:0][stat_width_p-1:0]      stall_cycles_o,
  output logic [stat_width_p-1:0]                         spurious_clear_o,
  output logic [stat_width_p-1:0]                         overwrite_o
);

  localparam logic [cls_w_lp:0] num_cls_lp = (cls_w_lp + 1)'(num_classes_p);

  logic                   valid_q [reg_els_p];
  logic [cls_w_lp-1:0]    class_q [reg_els_p];
  logic [age_width_p-1:0] age_q   [reg_els_p];

  logic                   set_ok;
  logic                   clr_hit;
  logic                   stall_hit;
  logic                   spurious_ev;
  logic                   overwrite_ev;
  logic [cls_w_lp-1:0]    done_cls;
  logic [age_width_p-1:0] done_age;
  logic [cls_w_lp-1:0]    stall_cls;

  // Out-of-range classes and (optionally) x0 destinations are not tracked.
  assign set_ok = set_v_i
               && ({1'b0, set_class_i} < num_cls_lp)
               && !(ignore_reg0_p && set_id_i == '0);

  // Completion, stall and error decisions all use pre-edge entry state.
  assign clr_hit      = clear_v_i && valid_q[clear_id_i];
  assign done_cls     = class_q[clear_id_i];
  assign done_age     = age_q[clear_id_i];
  assign stall_hit    = stall_v_i && valid_q[stall_id_i];
  assign stall_cls    = class_q[stall_id_i];
  assign spurious_ev  = clear_v_i && !valid_q[clear_id_i];
  // A same-cycle clear of the same register retires the old op normally.
  assign overwrite_ev = set_ok && valid_q[set_id_i]
                     && !(clear_v_i && clear_id_i == set_id_i);

  // NOTE: the entry array is reset explicitly; a leftover valid bit after
  // reset would produce a bogus completion, so this is not a plain RAM.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < reg_els_p; i++) begin
        valid_q[i] <= 1'b0;
        class_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < reg_els_p; i++) begin
        if (set_ok && set_id_i == id_w_lp'(i)) begin
          valid_q[i] <= 1'b1;
          class_q[i] <= set_class_i;
          age_q[i]   <= age_width_p'(1);
        end else if (clear_v_i && clear_id_i == id_w_lp'(i)) begin
          valid_q[i] <= 1'b0;
          age_q[i]   <= '0;
        end else if (valid_q[i] && age_q[i] != '1) begin
          age_q[i]   <= age_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      spurious_clear_o <= '0;
      overwrite_o      <= '0;
    end else if (clear_stats_i) begin
      spurious_clear_o <= '0;
      overwrite_o      <= '0;
    end else begin
      if (spurious_ev && spurious_clear_o != '1) spurious_clear_o <= spurious_clear_o + 1'b1;
      if (overwrite_ev && overwrite_o != '1)     overwrite_o      <= overwrite_o + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the loops so no
  // path leaves a bit unassigned, which would otherwise infer a latch.
  always_comb begin
    pending_o     = '0;
    outstanding_o = '0;
    for (int i = 0; i < reg_els_p; i++) begin
      for (int c = 0; c < num_classes_p; c++) begin
        pending_o[i][c]  = valid_q[i] && (class_q[i] == cls_w_lp'(c));
        outstanding_o[c] = outstanding_o[c] + (id_w_lp + 1)'(pending_o[i][c]);
      end
    end
  end

  for (genvar c = 0; c < num_classes_p; c++) begin : g_class
    vanilla_sb_class_stats #(
      .age_width_p  (age_width_p),
      .stat_width_p (stat_width_p)
    ) u_stats (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .clear_stats_i  (clear_stats_i),
      .done_v_i       (clr_hit && done_cls == cls_w_lp'(c)),
      .done_age_i     (done_age),
      .stall_v_i      (stall_hit && stall_cls == cls_w_lp'(c)),
      .done_count_o   (done_count_o[c]),
      .lat_sum_o      (lat_sum_o[c]),
      .lat_max_o      (lat_max_o[c]),
      .stall_cycles_o (stall_cycles_o[c])
    );
  end

endmodule
